cmd_queue_decoder: RTL and testbench

CMD_QUEUE_DECODER -- requirements
Module: cmd_queue_decoder

---
 rtl/cmd_queue_decoder.sv | 157 +++++++++++++++
 tb/tb_cmd_queue_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_queue_decoder.sv
// Register-driven command decoder: slot 0 carries a general command; slots 1..N push into per-channel FWFT queues.
// Optional build macro CMD_DROP_ZERO_LEN_EN: when defined, zero-length pushes are discarded instead of queued.
module cmd_queue_decoder #(
  parameter int AXIL_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int NUM_CHANNEL     = 2,
  parameter int TOP_LEN_WIDTH   = 20,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [AXIL_DATA_WIDTH*(NUM_CHANNEL+1)-1:0]          reg_down,
  input  logic [$clog2(NUM_CHANNEL+1)-1:0]                    access_addr,
  input  logic                                                write_valid,
  output logic [NUM_CHANNEL-1:0]                              cmd_valid,
  input  logic [NUM_CHANNEL-1:0]                              cmd_ready,
  output logic [NUM_CHANNEL*TOP_LEN_WIDTH-1:0]                cmd_len,
  output logic [NUM_CHANNEL*AXI_ADDR_WIDTH-1:0]               cmd_addr,
  output logic [NUM_CHANNEL-1:0]                              ch_running,
  output logic [NUM_CHANNEL-1:0]                              ch_restart,
  output logic [NUM_CHANNEL*$clog2(QUEUE_DEPTH+1)-1:0]        q_level,
  output logic [NUM_CHANNEL-1:0]                              q_overflow
);

  localparam int NUM_REGISTER = NUM_CHANNEL + 1;
  localparam int AA_W         = $clog2(NUM_REGISTER);
  localparam int LVL_W        = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W        = $clog2(QUEUE_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [AXIL_DATA_WIDTH-1:0] gen_cmd;
  logic                       gen_wr;
  logic                       do_restart;
  logic                       do_start;
  logic                       do_stop;

  // The whole slot-0 word must match; any other value is ignored.
  assign gen_cmd    = reg_down[AXIL_DATA_WIDTH-1:0];
  assign gen_wr     = write_valid && (access_addr == '0);
  assign do_restart = gen_wr && (gen_cmd == AXIL_DATA_WIDTH'(1));
  assign do_start   = gen_wr && (gen_cmd == AXIL_DATA_WIDTH'(2));
  assign do_stop    = gen_wr && (gen_cmd == AXIL_DATA_WIDTH'(3));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNEL; gi++) begin : g_ch
      state_t                     state_q, state_d;
      logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
      logic [LVL_W-1:0]           level_q, level_d;
      logic                       ovf_q, ovf_d;
      logic                       restart_q, restart_d;
      logic [TOP_LEN_WIDTH-1:0]   len_mem  [QUEUE_DEPTH];
      logic [AXI_ADDR_WIDTH-1:0]  addr_mem [QUEUE_DEPTH];
      logic [AXIL_DATA_WIDTH-1:0] slot;
      logic [TOP_LEN_WIDTH-1:0]   push_len;
      logic [AXI_ADDR_WIDTH-1:0]  push_addr;
      logic                       push_req;
      logic                       push_ok;
      logic                       pop;
      logic                       valid;
      logic                       unused_slot_bits;

      assign slot             = reg_down[(gi+1)*AXIL_DATA_WIDTH +: AXIL_DATA_WIDTH];
      assign push_len         = slot[TOP_LEN_WIDTH-1:0];
      assign push_addr        = slot[32 +: AXI_ADDR_WIDTH];
      assign unused_slot_bits = ^slot;

`ifdef CMD_DROP_ZERO_LEN_EN
      assign push_req = write_valid && (access_addr == AA_W'(gi + 1)) && (push_len != '0);
`else
      assign push_req = write_valid && (access_addr == AA_W'(gi + 1));
`endif

      assign valid   = (state_q == ST_RUN) && (level_q != '0);
      assign pop     = valid && cmd_ready[gi];
      // A full queue still takes the push when the head leaves in the same cycle.
      assign push_ok = push_req && ((level_q != LVL_W'(QUEUE_DEPTH)) || pop);

      always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        restart_d = 1'b0;
        if (do_restart) begin
          state_d   = ST_IDLE;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          level_d   = '0;
          ovf_d     = 1'b0;
          restart_d = 1'b1;
        end else begin
          if ((state_q == ST_IDLE) && do_start) begin
            state_d = ST_RUN;
          end else if ((state_q == ST_RUN) && do_stop) begin
            state_d = ST_IDLE;
          end
          if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
          if (push_ok && !pop) begin
            level_d = level_q + LVL_W'(1);
          end else if (!push_ok && pop) begin
            level_d = level_q - LVL_W'(1);
          end
          if (push_req && !push_ok) begin
            ovf_d = 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q   <= ST_IDLE;
          wr_ptr_q  <= '0;
          rd_ptr_q  <= '0;
          level_q   <= '0;
          ovf_q     <= 1'b0;
          restart_q <= 1'b0;
        end else begin
          state_q   <= state_d;
          wr_ptr_q  <= wr_ptr_d;
          rd_ptr_q  <= rd_ptr_d;
          level_q   <= level_d;
          ovf_q     <= ovf_d;
          restart_q <= restart_d;
        end
      end

      // Payload storage carries no reset; pointers and level define what is valid.
      always_ff @(posedge clk) begin
        if (!rst && !do_restart && push_ok) begin
          len_mem[wr_ptr_q]  <= push_len;
          addr_mem[wr_ptr_q] <= push_addr;
        end
      end

      assign cmd_valid[gi]                                  = valid;
      assign cmd_len[gi*TOP_LEN_WIDTH +: TOP_LEN_WIDTH]     = len_mem[rd_ptr_q];
      assign cmd_addr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]  = addr_mem[rd_ptr_q];
      assign ch_running[gi]                                 = (state_q == ST_RUN);
      assign ch_restart[gi]                                 = restart_q;
      assign q_level[gi*LVL_W +: LVL_W]                     = level_q;
      assign q_overflow[gi]                                 = ovf_q;
    end
  endgenerate

endmodule

// File: tb/tb_cmd_queue_decoder.sv
// Bench for cmd_queue_decoder: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-based model of the channel behaviour.
module tb_cmd_queue_decoder;

  localparam int NC    = 2;
  localparam int DEPTH = 4;
`ifdef CMD_DROP_ZERO_LEN_EN
  localparam bit DROP0 = 1'b1;
`else
  localparam bit DROP0 = 1'b0;
`endif

  typedef struct packed {
    logic [19:0] len;
    logic [31:0] addr;
  } cmd_t;

  logic          clk;
  logic          rst;
  logic [191:0]  reg_down;
  logic [1:0]    access_addr;
  logic          write_valid;
  logic [1:0]    cmd_valid;
  logic [1:0]    cmd_ready;
  logic [39:0]   cmd_len;
  logic [63:0]   cmd_addr;
  logic [1:0]    ch_running;
  logic [1:0]    ch_restart;
  logic [5:0]    q_level;
  logic [1:0]    q_overflow;

  int tests;
  int fails;
  bit chk_en;

  cmd_t mq [NC][$];
  bit   m_run   [NC];
  bit   m_ovf   [NC];
  bit   m_pulse [NC];

  cmd_queue_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .reg_down    (reg_down),
    .access_addr (access_addr),
    .write_valid (write_valid),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .cmd_addr    (cmd_addr),
    .ch_running  (ch_running),
    .ch_restart  (ch_restart),
    .q_level     (q_level),
    .q_overflow  (q_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: channel state advanced at each rising edge from the sampled inputs.
  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        mq[c].delete();
        m_run[c]   = 1'b0;
        m_ovf[c]   = 1'b0;
        m_pulse[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        bit   pop_m;
        bit   push_m;
        bit   gen_m;
        cmd_t nc;
        gen_m    = write_valid && (access_addr == 2'd0);
        pop_m    = m_run[c] && (mq[c].size() > 0) && cmd_ready[c];
        push_m   = write_valid && (int'(access_addr) == c + 1);
        nc.len   = reg_down[(c+1)*64 +: 20];
        nc.addr  = reg_down[(c+1)*64 + 32 +: 32];
        if (DROP0 && nc.len == 20'd0) push_m = 1'b0;
        m_pulse[c] = 1'b0;
        if (gen_m && reg_down[63:0] == 64'd1) begin
          mq[c].delete();
          m_run[c]   = 1'b0;
          m_ovf[c]   = 1'b0;
          m_pulse[c] = 1'b1;
        end else begin
          if (pop_m) void'(mq[c].pop_front());
          if (push_m) begin
            if (mq[c].size() < DEPTH) mq[c].push_back(nc);
            else m_ovf[c] = 1'b1;
          end
          if (gen_m && reg_down[63:0] == 64'd2) m_run[c] = 1'b1;
          else if (gen_m && reg_down[63:0] == 64'd3) m_run[c] = 1'b0;
        end
      end
    end
  end

  // Compare process: outputs sampled mid-cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        bit ev;
        ev = m_run[c] && (mq[c].size() > 0);
        chk($sformatf("m_valid%0d", c), 64'(cmd_valid[c]), 64'(ev));
        chk($sformatf("m_running%0d", c), 64'(ch_running[c]), 64'(m_run[c]));
        chk($sformatf("m_restart%0d", c), 64'(ch_restart[c]), 64'(m_pulse[c]));
        chk($sformatf("m_level%0d", c), 64'(q_level[c*3 +: 3]), 64'(mq[c].size()));
        chk($sformatf("m_ovf%0d", c), 64'(q_overflow[c]), 64'(m_ovf[c]));
        if (ev) begin
          chk($sformatf("m_len%0d", c), 64'(cmd_len[c*20 +: 20]), 64'(mq[c][0].len));
          chk($sformatf("m_addr%0d", c), 64'(cmd_addr[c*32 +: 32]), 64'(mq[c][0].addr));
        end
      end
    end
  end

  task automatic wr(input int a, input logic [63:0] d);
    reg_down[a*64 +: 64] = d;
    access_addr = 2'(a);
    write_valid = 1'b1;
    @(negedge clk);
    write_valid = 1'b0;
  endtask

  task automatic push(input int ch, input logic [19:0] len, input logic [31:0] addr);
    wr(ch + 1, {addr, 12'h0, len});
  endtask

  task automatic gcmd(input int v);
    wr(0, 64'(v));
  endtask

  initial begin
    logic [19:0] e [4];
    tests       = 0;
    fails       = 0;
    chk_en      = 1'b0;
    rst         = 1'b1;
    reg_down    = '0;
    access_addr = '0;
    write_valid = 1'b0;
    cmd_ready   = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_level", 64'(q_level), 64'd0);
    chk("rst_ovf", 64'(q_overflow), 64'd0);
    chk("rst_running", 64'(ch_running), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single command through channel 0
    push(0, 20'h10, 32'h1000_0000);
    gcmd(2);
    chk("s1_valid", 64'(cmd_valid[0]), 64'd1);
    chk("s1_len", 64'(cmd_len[19:0]), 64'h10);
    chk("s1_addr", 64'(cmd_addr[31:0]), 64'h1000_0000);
    cmd_ready = 2'b01;
    @(negedge clk);
    cmd_ready = 2'b00;
    chk("s1_level", 64'(q_level[2:0]), 64'd0);
    chk("s1_valid_after", 64'(cmd_valid[0]), 64'd0);

    // Overflow on channel 1
    gcmd(1);
    chk("s2_restart_pulse", 64'(ch_restart), 64'd3);
    @(negedge clk);
    chk("s2_restart_done", 64'(ch_restart), 64'd0);
    for (int i = 1; i <= 5; i++) push(1, 20'(i), 32'hA000_0000 + 32'(i));
    chk("s2_level", 64'(q_level[5:3]), 64'd4);
    chk("s2_ovf", 64'(q_overflow), 64'd2);
    gcmd(2);
    chk("s2_valid", 64'(cmd_valid[1]), 64'd1);
    chk("s2_head_len", 64'(cmd_len[39:20]), 64'd1);
    chk("s2_head_addr", 64'(cmd_addr[63:32]), 64'hA000_0001);

    // Full queue with simultaneous push and pop
    gcmd(1);
    for (int i = 1; i <= 4; i++) push(1, 20'(i), 32'hA000_0000 + 32'(i));
    gcmd(2);
    chk("s3_full", 64'(q_level[5:3]), 64'd4);
    cmd_ready = 2'b10;
    push(1, 20'd6, 32'hA000_0006);
    chk("s3_level", 64'(q_level[5:3]), 64'd4);
    chk("s3_ovf", 64'(q_overflow[1]), 64'd0);
    e[0] = 20'd2; e[1] = 20'd3; e[2] = 20'd4; e[3] = 20'd6;
    for (int j = 0; j < 4; j++) begin
      chk("s3_order", 64'(cmd_len[39:20]), 64'(e[j]));
      @(negedge clk);
    end
    cmd_ready = 2'b00;
    chk("s3_drained", 64'(q_level[5:3]), 64'd0);

    // Restart with queued commands
    gcmd(1);
    for (int i = 0; i < 3; i++) push(0, 20'h30 + 20'(i), 32'hC000_0000);
    gcmd(2);
    chk("s4_queued", 64'(q_level[2:0]), 64'd3);
    gcmd(1);
    chk("s4_level", 64'(q_level[2:0]), 64'd0);
    chk("s4_pulse", 64'(ch_restart), 64'd3);
    chk("s4_valid", 64'(cmd_valid), 64'd0);
    chk("s4_running", 64'(ch_running), 64'd0);
    @(negedge clk);
    chk("s4_pulse_end", 64'(ch_restart), 64'd0);

    // Stop preserves queue contents
    push(0, 20'h21, 32'hB000_0000);
    push(0, 20'h22, 32'hB000_0010);
    gcmd(2);
    chk("s5_valid", 64'(cmd_valid[0]), 64'd1);
    gcmd(3);
    chk("s5_stop_valid", 64'(cmd_valid[0]), 64'd0);
    chk("s5_stop_level", 64'(q_level[2:0]), 64'd2);
    gcmd(2);
    chk("s5_resume_valid", 64'(cmd_valid[0]), 64'd1);
    chk("s5_resume_len", 64'(cmd_len[19:0]), 64'h21);
    chk("s5_resume_addr", 64'(cmd_addr[31:0]), 64'hB000_0000);

    // Zero-length push, then an out-of-range slot write
    gcmd(1);
    push(0, 20'd0, 32'hC000_0000);
    chk("s6_zero_len", 64'(q_level[2:0]), DROP0 ? 64'd0 : 64'd1);
    access_addr = 2'd3;
    write_valid = 1'b1;
    @(negedge clk);
    write_valid = 1'b0;
    chk("s6_oob_l0", 64'(q_level[2:0]), DROP0 ? 64'd0 : 64'd1);
    chk("s6_oob_l1", 64'(q_level[5:3]), 64'd0);

    // Randomized traffic, including occasional reset mid-transfer
    for (int i = 0; i < 4000; i++) begin
      int r;
      rst         = ($urandom_range(0, 299) == 0);
      cmd_ready   = 2'($urandom_range(0, 3));
      write_valid = ($urandom_range(0, 2) != 0);
      r           = $urandom_range(0, 9);
      access_addr = (r < 2) ? 2'd0 : (r < 9) ? 2'($urandom_range(1, 2)) : 2'd3;
      r = $urandom_range(0, 19);
      if (r < 1)       reg_down[63:0] = 64'd1;
      else if (r < 9)  reg_down[63:0] = 64'd2;
      else if (r < 13) reg_down[63:0] = 64'd3;
      else if (r < 16) reg_down[63:0] = 64'd0;
      else             reg_down[63:0] = {$urandom, $urandom};
      for (int k = 1; k <= NC; k++) begin
        logic [19:0] l;
        l = ($urandom_range(0, 7) == 0) ? 20'd0 : 20'($urandom_range(1, 20'hFFFFF));
        reg_down[k*64 +: 64] = {32'($urandom), 12'($urandom), l};
      end
      @(negedge clk);
    end
    rst         = 1'b0;
    write_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
